// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Bus-side controller for an 8 x 16-bit register file. It accepts single
//   read/write commands over a valid/ready handshake, returns read data on a
//   valid/ready response channel, and runs an init sweep that writes
//   INIT_VALUE to every register. One command is in flight at a time; every
//   register-file-side output is registered.
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata     command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready      read response handshake
//   rsp_rdata                captured read data
//   init_start               request an init sweep (honoured only in IDLE)
//   busy                     registered, high whenever the FSM is not in IDLE
//   init_done                one-cycle pulse when the sweep completes
//   WrEn/RdEn/Address/WrData register file command port
//   RdData                   register file read data
//
// RD_LATENCY must lie in 1..4; the wait counter is sized for that range.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for init_start or a command
// S_WR      | WrEn high for the accepted write
// S_RD      | RdEn high for the accepted read
// S_RD_WAIT | counting down the register file read latency
// S_RSP     | holding rsp_valid/rsp_rdata until rsp_ready
// S_INIT    | sweeping Address 0..DEPTH-1 with WrEn high

module reg_file_ctrl #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 3,
   parameter int                    RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 16'h0000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  init_start,
   output logic                  busy,
   output logic                  init_done,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData
);

   localparam int CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_WAIT,
      S_RSP,
      S_INIT
   } state_t;

   state_t                r_state;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_busy;
   logic                  r_init_done;
   logic [CNT_W-1:0]      r_cnt;

   state_t                w_state_nxt;
   logic                  w_wr_en_nxt;
   logic                  w_rd_en_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_wdata_nxt;
   logic                  w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
   logic                  w_init_done_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_cmd_ready;

   // init_start wins over a simultaneous command, so it masks cmd_ready.
   assign w_cmd_ready = (r_state == S_IDLE) & ~RST & ~init_start;

   always_comb begin
      w_state_nxt     = r_state;
      w_wr_en_nxt     = 1'b0;
      w_rd_en_nxt     = 1'b0;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_init_done_nxt = 1'b0;
      w_cnt_nxt       = r_cnt;

      case (r_state)
         S_IDLE: begin
            if (init_start) begin
               w_addr_nxt  = '0;
               w_wdata_nxt = INIT_VALUE;
               w_wr_en_nxt = 1'b1;
               w_state_nxt = S_INIT;
            end else if (cmd_valid) begin
               w_addr_nxt = cmd_addr;
               if (cmd_write) begin
                  w_wdata_nxt = cmd_wdata;
                  w_wr_en_nxt = 1'b1;
                  w_state_nxt = S_WR;
               end else begin
                  w_rd_en_nxt = 1'b1;
                  w_state_nxt = S_RD;
               end
            end
         end

         S_WR: begin
            w_state_nxt = S_IDLE;
         end

         S_RD: begin
            w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
            w_state_nxt = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (r_cnt == '0) begin
               w_rsp_rdata_nxt = RdData;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RSP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         S_RSP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end

         S_INIT: begin
            // Address already holds the last register: that write is done.
            if (&r_addr) begin
               w_init_done_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end else begin
               w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
               w_wr_en_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_rd_en     <= w_rd_en_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_init_done <= w_init_done_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign busy      = r_busy;
   assign init_done = r_init_done;
   assign WrEn      = r_wr_en;
   assign RdEn      = r_rd_en;
   assign Address   = r_addr;
   assign WrData    = r_wdata;

endmodule

// File: tb/tb_reg_file_ctrl.sv
module tb_reg_file_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_write;
   logic [2:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_ready;
   logic        init_start;

   logic        a_cmd_ready, a_rsp_valid, a_busy, a_init_done, a_WrEn, a_RdEn;
   logic [15:0] a_rsp_rdata, a_WrData, a_RdData;
   logic [2:0]  a_Address;
   logic        b_cmd_ready, b_rsp_valid, b_busy, b_init_done, b_WrEn, b_RdEn;
   logic [15:0] b_rsp_rdata, b_WrData, b_RdData;
   logic [2:0]  b_Address;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   reg_file_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .RD_LATENCY(1), .INIT_VALUE(16'hA5A5)) u_dut_a (
      .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
      .init_start(init_start), .busy(a_busy), .init_done(a_init_done),
      .WrEn(a_WrEn), .RdEn(a_RdEn), .Address(a_Address), .WrData(a_WrData),
      .RdData(a_RdData));

   reg_file_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .RD_LATENCY(3), .INIT_VALUE(16'hA5A5)) u_dut_b (
      .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
      .init_start(init_start), .busy(b_busy), .init_done(b_init_done),
      .WrEn(b_WrEn), .RdEn(b_RdEn), .Address(b_Address), .WrData(b_WrData),
      .RdData(b_RdData));

   // Register file models: latency 1 for A, latency 3 for B.
   logic [15:0] a_mem [8] = '{default: 16'h0000};
   logic [15:0] a_pipe = 16'h0000;
   logic [15:0] b_mem [8] = '{default: 16'h0000};
   logic [15:0] b_p0 = 16'h0000, b_p1 = 16'h0000, b_p2 = 16'h0000;

   always @(posedge CLK) begin
      if (a_WrEn) a_mem[a_Address] <= a_WrData;
      if (a_RdEn) a_pipe <= a_mem[a_Address];
      if (b_WrEn) b_mem[b_Address] <= b_WrData;
      if (b_RdEn) b_p0 <= b_mem[b_Address];
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end
   assign a_RdData = a_pipe;
   assign b_RdData = b_p2;

   typedef struct packed {
      logic        write;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_WrEn"},      32'(a_WrEn),      32'd0);
      chk({tag, "_RdEn"},      32'(a_RdEn),      32'd0);
      chk({tag, "_Address"},   32'(a_Address),   32'd0);
      chk({tag, "_WrData"},    32'(a_WrData),    32'd0);
      chk({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(a_rsp_rdata), 32'd0);
      chk({tag, "_busy"},      32'(a_busy),      32'd0);
      chk({tag, "_init_done"}, 32'(a_init_done), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(a_cmd_ready), 32'd0);
   endtask

   // Issue one command to DUT A (rsp_ready assumed high) and check it.
   task automatic run_cmd(input logic wr, input logic [2:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp);
      int n;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      #1;
      chk("cmd_ready_idle", 32'(a_cmd_ready), 32'd1);
      cyc();
      cmd_valid = 1'b0;
      chk("busy_accept", 32'(a_busy), 32'd1);
      chk("addr_accept", 32'(a_Address), 32'(addr));
      if (wr) begin
         chk("wr_en", 32'(a_WrEn), 32'd1);
         chk("wr_data", 32'(a_WrData), 32'(wdata));
         chk("wr_rd_en", 32'(a_RdEn), 32'd0);
         cyc();
         chk("wr_en_drop", 32'(a_WrEn), 32'd0);
      end else begin
         chk("rd_en", 32'(a_RdEn), 32'd1);
         chk("rd_wr_en", 32'(a_WrEn), 32'd0);
         n = 0;
         do begin
            cyc();
            n++;
         end while (!a_rsp_valid && n < 10);
         chk("rsp_latency", 32'(n), 32'd2);
         chk("rsp_rdata", 32'(a_rsp_rdata), 32'(exp));
         cyc();
         chk("rsp_valid_drop", 32'(a_rsp_valid), 32'd0);
      end
   endtask

   initial begin
      logic seen;
      vecs[0] = '{write: 1'b1, addr: 3'd4, wdata: 16'd10,    exp_rdata: 16'h0000};
      vecs[1] = '{write: 1'b1, addr: 3'd7, wdata: 16'hBEEF, exp_rdata: 16'h0000};
      vecs[2] = '{write: 1'b1, addr: 3'd0, wdata: 16'hFFFF, exp_rdata: 16'h0000};
      vecs[3] = '{write: 1'b0, addr: 3'd4, wdata: 16'h0000, exp_rdata: 16'd10};
      vecs[4] = '{write: 1'b0, addr: 3'd7, wdata: 16'h0000, exp_rdata: 16'hBEEF};
      vecs[5] = '{write: 1'b0, addr: 3'd0, wdata: 16'h0000, exp_rdata: 16'hFFFF};
      vecs[6] = '{write: 1'b0, addr: 3'd1, wdata: 16'h0000, exp_rdata: 16'd17};
      vecs[7] = '{write: 1'b1, addr: 3'd6, wdata: 16'h1234, exp_rdata: 16'h0000};
      vecs[8] = '{write: 1'b0, addr: 3'd6, wdata: 16'h0000, exp_rdata: 16'h1234};

      RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b1; init_start = 1'b0;
      cyc();
      cyc();
      chk_reset("reset");
      RST = 1'b0;

      // Write 17 to address 1 (both DUTs accept).
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_wdata = 16'd17;
      #1;
      chk("w17_ready", 32'(a_cmd_ready), 32'd1);
      cyc();
      cmd_valid = 1'b0;
      chk("w17_WrEn", 32'(a_WrEn), 32'd1);
      chk("w17_Address", 32'(a_Address), 32'd1);
      chk("w17_WrData", 32'(a_WrData), 32'd17);
      chk("w17_ready_low", 32'(a_cmd_ready), 32'd0);
      cyc();
      chk("w17_WrEn_drop", 32'(a_WrEn), 32'd0);
      chk("w17_ready_high", 32'(a_cmd_ready), 32'd1);

      // Read address 1: latency 1 responds at E+2, latency 3 at E+4.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1;
      cyc();
      cmd_valid = 1'b0;
      chk("lat_a_RdEn", 32'(a_RdEn), 32'd1);
      chk("lat_b_RdEn", 32'(b_RdEn), 32'd1);
      cyc();
      chk("lat_a_RdEn_drop", 32'(a_RdEn), 32'd0);
      chk("lat_a_e1", 32'(a_rsp_valid), 32'd0);
      cyc();
      chk("lat_a_e2", 32'(a_rsp_valid), 32'd1);
      chk("lat_a_rdata", 32'(a_rsp_rdata), 32'd17);
      chk("lat_b_e2", 32'(b_rsp_valid), 32'd0);
      cyc();
      chk("lat_a_e3", 32'(a_rsp_valid), 32'd0);
      chk("lat_b_e3", 32'(b_rsp_valid), 32'd0);
      cyc();
      chk("lat_b_e4", 32'(b_rsp_valid), 32'd1);
      chk("lat_b_rdata", 32'(b_rsp_rdata), 32'd17);
      cyc();
      chk("lat_b_e5", 32'(b_rsp_valid), 32'd0);
      chk("lat_b_busy", 32'(b_busy), 32'd0);

      for (int i = 0; i < 9; i++)
         run_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

      // Back-pressure: read addr 4 (=10), rsp_ready low for 5 cycles.
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd4;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      cyc();
      chk("bp_valid_rise", 32'(a_rsp_valid), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 16'h0055;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid_hold", 32'(a_rsp_valid), 32'd1);
         chk("bp_rdata_hold", 32'(a_rsp_rdata), 32'd10);
         chk("bp_ready_low", 32'(a_cmd_ready), 32'd0);
         chk("bp_no_write", 32'(a_WrEn), 32'd0);
         cyc();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      cyc();
      chk("bp_valid_drop", 32'(a_rsp_valid), 32'd0);
      chk("bp_addr2_untouched", 32'(a_mem[2]), 32'd0);

      // init_start and a write in the same IDLE cycle: sweep first.
      init_start = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_wdata = 16'h0077;
      #1;
      chk("init_masks_ready", 32'(a_cmd_ready), 32'd0);
      cyc();
      init_start = 1'b0;
      chk("init_WrData", 32'(a_WrData), 32'hA5A5);
      for (int i = 0; i < 8; i++) begin
         chk("init_WrEn", 32'(a_WrEn), 32'd1);
         chk("init_Address", 32'(a_Address), 32'(i));
         chk("init_busy", 32'(a_busy), 32'd1);
         chk("init_done_early", 32'(a_init_done), 32'd0);
         chk("init_ready_low", 32'(a_cmd_ready), 32'd0);
         cyc();
      end
      chk("init_done_pulse", 32'(a_init_done), 32'd1);
      chk("init_WrEn_end", 32'(a_WrEn), 32'd0);
      chk("init_busy_end", 32'(a_busy), 32'd0);
      chk("init_ready_end", 32'(a_cmd_ready), 32'd1);
      cyc();
      cmd_valid = 1'b0;
      chk("init_done_once", 32'(a_init_done), 32'd0);
      chk("post_init_WrEn", 32'(a_WrEn), 32'd1);
      chk("post_init_Address", 32'(a_Address), 32'd5);
      chk("post_init_WrData", 32'(a_WrData), 32'h0077);
      cyc();
      run_cmd(1'b0, 3'd1, 16'h0000, 16'hA5A5);
      run_cmd(1'b0, 3'd4, 16'h0000, 16'hA5A5);
      run_cmd(1'b0, 3'd5, 16'h0000, 16'h0077);

      // Reset during RD_WAIT.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd4;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      RST = 1'b1;
      #1;
      chk("rst_rdwait_ready", 32'(a_cmd_ready), 32'd0);
      cyc();
      chk_reset("rst_rdwait");
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         seen = seen | a_rsp_valid | a_RdEn | a_WrEn;
      end
      chk("rst_rdwait_quiet", 32'(seen), 32'd0);

      // Reset during INIT at Address 3.
      init_start = 1'b1;
      cyc();
      init_start = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("rst_init_addr3", 32'(a_Address), 32'd3);
      RST = 1'b1;
      cyc();
      chk_reset("rst_init");
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         seen = seen | a_init_done | a_WrEn | a_RdEn | a_rsp_valid;
      end
      chk("rst_init_quiet", 32'(seen), 32'd0);
      chk("rst_init_addr5_kept", 32'(a_mem[5]), 32'h0077);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Bus-side controller that drives the 8 x 16-bit register file's WrEn/RdEn/Address/WrData port and captures RdData. Upstream logic issues single read or write commands over a valid/ready handshake and gets read data back on a valid/ready response channel. The controller also runs an autonomous init sweep that writes INIT_VALUE to every register. One command is in flight at a time, and all register-file-side outputs are registered.

## Interface
- DATA_WIDTH, 16, register width
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH
- RD_LATENCY, 1, edges from the edge where the register file samples RdEn=1 to the edge where RdData is captured; legal range 1..4
- INIT_VALUE, 16'h0000, value written by the init sweep

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid; combinational
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target register
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  captured read data
- init_start  in  1  request init sweep
- busy  out  1  controller not in IDLE
- init_done  out  1  one-cycle pulse at sweep completion
- WrEn  out  1  register file write enable
- RdEn  out  1  register file read enable
- Address  out  ADDR_WIDTH  register file address
- WrData  out  DATA_WIDTH  register file write data
- RdData  in  DATA_WIDTH  register file read data

## Operation
- The FSM has states IDLE, WR, RD, RD_WAIT, RSP, INIT. Transitions happen on the rising edge of CLK.
- In IDLE:
  - cmd_ready = ~RST & ~init_start.
  - init_start has priority over cmd_valid in the same cycle.
  - cmd_* inputs are ignored whenever cmd_ready is low.
  - init_start is ignored outside IDLE.
- Write accepted at edge E:
  - Address<=cmd_addr, WrData<=cmd_wdata, WrEn<=1; state goes to WR.
  - At E+1: WrEn<=0; state goes to IDLE.
  - A write produces no response.
- Read accepted at edge E:
  - Address<=cmd_addr, RdEn<=1; state goes to RD.
  - At E+1: RdEn<=0; a wait counter loads RD_LATENCY-1; state goes to RD_WAIT.
  - In RD_WAIT, the counter decrements each edge. At the edge where it reads 0, rsp_rdata<=RdData and rsp_valid<=1; state goes to RSP.
  - The capture edge is E+1+RD_LATENCY.
- In RSP:
  - rsp_valid and rsp_rdata are held stable until rsp_valid&rsp_ready at an edge.
  - At that edge rsp_valid<=0; state goes to IDLE.
  - There is no timeout.
- INIT, triggered at edge E:
  - Address<=0, WrData<=INIT_VALUE, WrEn<=1; state goes to INIT.
  - Each following edge Address increments by 1.
  - At the edge where Address==DEPTH-1: WrEn<=0, init_done<=1 for one cycle; state goes to IDLE.
  - Result is exactly DEPTH writes with no gaps.
- Address and WrData hold their last values while idle and do not return to 0.
- busy is registered and equals (next state != IDLE). This gives busy=1 from the acceptance edge until the edge returning to IDLE.
- WrEn and RdEn are never high together.

## Timing
- Reset values after an edge with RST=1: WrEn=0, RdEn=0, Address=0, WrData=0, rsp_valid=0, rsp_rdata=0, busy=0, init_done=0, state=IDLE. cmd_ready is 0 while RST is high.
- Reset mid-operation abandons the transaction. No response is issued and the init sweep stops. Registers already written stay written.
- Write command: WrEn is high for exactly 1 cycle. cmd_ready is low for 1 cycle, so sustained write throughput is 1 per 2 cycles.
- Read command: RdEn is high for exactly 1 cycle. rsp_valid rises RD_LATENCY+1 cycles after the acceptance edge. The next command can be accepted in the cycle after the response handshake.
- Init: busy is high for DEPTH cycles. init_done pulses in the cycle after the last WrEn cycle.
- RST has priority over every other input in the same cycle.

## Test plan
- Reset, then write 17 to address 1 -> WrEn=1, Address=1, WrData=17 for exactly one cycle. cmd_ready is low that cycle and high the next.
- Write 17 to address 1, then read address 1 with rsp_ready=1 -> rsp_valid pulses with rsp_rdata=17 at acceptance+2 (RD_LATENCY=1). Repeat with RD_LATENCY=3 -> the pulse moves to acceptance+4.
- Read address 4 (containing 10) while holding rsp_ready=0 for 5 cycles -> rsp_valid stays high and rsp_rdata stays 10. cmd_ready stays low and a cmd_valid presented meanwhile is not accepted.
- Write 10 to address 4, then init_start with INIT_VALUE=16'hA5A5 -> 8 consecutive WrEn cycles with Address 0..7, busy high for 8 cycles, one init_done pulse. Reading addresses 1 and 4 afterwards returns 16'hA5A5.
- Assert init_start and cmd_valid (write) in the same IDLE cycle -> the sweep runs, and the write is accepted only after init_done.
- Assert RST during RD_WAIT and during INIT (Address=3) -> all outputs reach their reset values at the next edge. No rsp_valid or init_done is ever produced, and RdEn/WrEn stay low.
